// File: rtl/imm_load_ctrl.sv
// imm_load_ctrl
// Builds 8-bit register-file writes out of 4-bit immediate nibbles.
//   ZEXT  (00): write {0000, nib} to rd
//   PAIR  (01): two back-to-back PAIR requests write {hi_nib, lo_nib} to the
//               rd of the first request
//   SHIFT (10): write {acc[3:0], nib} to rd, where acc is the last committed value
//   11        : reserved, rejected with a one-cycle err pulse
//
// Ports
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   flush                 : synchronous abort back to IDLE (beats wr_ready)
//   in_valid/in_ready     : request handshake, in_op/in_nib/in_rd request payload
//   wr_valid/wr_ready     : write handshake, wr_addr/wr_data write payload
//   busy                  : high whenever the controller is not IDLE
//   err                   : one-cycle pulse after an illegal request is accepted
module imm_load_ctrl #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [3:0]        in_nib,
    input  logic [ADDR_W-1:0] in_rd,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] OP_ZEXT  = 2'b00;
    localparam logic [1:0] OP_PAIR  = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        acc;
    logic [3:0]        lo_nib;
    logic [ADDR_W-1:0] pair_rd;
    logic              accept;

    // A write in flight blocks new requests; flush blocks them too, so a
    // request can never be swallowed by the same edge that aborts.
    assign in_ready = (state != WRITE) && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            acc      <= 8'h00;
            lo_nib   <= 4'h0;
            pair_rd  <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (flush) begin
                // Abandoned writes never reach acc.
                state    <= IDLE;
                wr_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            case (in_op)
                                OP_ZEXT: begin
                                    wr_data  <= {4'b0000, in_nib};
                                    wr_addr  <= in_rd;
                                    wr_valid <= 1'b1;
                                    state    <= WRITE;
                                end
                                OP_PAIR: begin
                                    lo_nib  <= in_nib;
                                    pair_rd <= in_rd;
                                    state   <= WAIT_HI;
                                end
                                OP_SHIFT: begin
                                    wr_data  <= {acc[3:0], in_nib};
                                    wr_addr  <= in_rd;
                                    wr_valid <= 1'b1;
                                    state    <= WRITE;
                                end
                                default: err <= 1'b1;
                            endcase
                        end
                    end
                    WAIT_HI: begin
                        // No timeout: the low half waits as long as needed.
                        if (accept) begin
                            if (in_op == OP_PAIR) begin
                                wr_data  <= {in_nib, lo_nib};
                                wr_addr  <= pair_rd;
                                wr_valid <= 1'b1;
                                state    <= WRITE;
                            end else begin
                                err    <= 1'b1;
                                lo_nib <= 4'h0;
                                state  <= IDLE;
                            end
                        end
                    end
                    WRITE: begin
                        if (wr_ready) begin
                            acc      <= wr_data;
                            wr_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        wr_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/imm_load_ctrl.md
IMM_LOAD_CTRL -- requirements
Module: imm_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, the destination register address width.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port flush, input, 1, synchronous abort of any pending operation.
REQ-005 SHALL have port in_valid, input, 1, a nibble request is present.
REQ-006 SHALL have port in_ready, output, 1, the block accepts a request this cycle.
REQ-007 SHALL have port in_op, input, 2, the operation: 00 ZEXT, 01 PAIR, 10 SHIFT, 11 reserved.
REQ-008 SHALL have port in_nib, input, 4, the immediate nibble.
REQ-009 SHALL have port in_rd, input, ADDR_W, the destination register.
REQ-010 SHALL have port wr_valid, output, 1, a register write is pending.
REQ-011 SHALL have port wr_ready, input, 1, the register file accepts the write.
REQ-012 SHALL have port wr_addr, output, ADDR_W, the write destination.
REQ-013 SHALL have port wr_data, output, 8, the write value.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port err, output, 1, a one-cycle pulse on an illegal request.

Function
REQ-016 SHALL implement the states IDLE, WAIT_HI and WRITE, and SHALL hold an 8-bit register acc containing the last committed wr_data.
REQ-017 SHALL drive in_ready = (state != WRITE) && !flush, combinationally.
REQ-018 SHALL treat a request as accepted only when in_valid && in_ready are both high on a rising clk edge.
REQ-019 On an accepted ZEXT in IDLE, SHALL load wr_data = {4'b0000, in_nib} and wr_addr = in_rd, then enter WRITE, so that wr_valid is high on the next cycle (latency 1).
REQ-020 On an accepted PAIR in IDLE, SHALL latch in_nib as the low nibble, latch in_rd, enter WAIT_HI, and issue no write.
REQ-021 In WAIT_HI, on an accepted request with in_op = PAIR, SHALL load wr_data = {in_nib, latched_low}, load wr_addr = the latched rd (ignoring the new in_rd), and enter WRITE.
REQ-022 In WAIT_HI, on an accepted request with in_op other than PAIR, SHALL pulse err, discard the latched low nibble, return to IDLE, and issue no write.
REQ-023 On an accepted SHIFT in IDLE, SHALL load wr_data = {acc[3:0], in_nib} and wr_addr = in_rd, then enter WRITE.
REQ-024 On an accepted reserved op (11) in IDLE, SHALL pulse err for one cycle, stay in IDLE, and issue no write.
REQ-025 In WRITE, SHALL hold wr_valid = 1 with wr_addr and wr_data stable until wr_ready is high.
REQ-026 On wr_valid && wr_ready, SHALL set acc = wr_data, clear wr_valid on the next cycle, and return to IDLE; a new request can therefore be accepted one cycle after the handshake.
REQ-027 In WAIT_HI, in_valid low SHALL hold the state indefinitely, with no timeout.
REQ-028 flush high SHALL force IDLE on the next edge from any state, with wr_valid = 0 and acc unchanged.
REQ-029 flush SHALL take priority over wr_ready; a write abandoned by flush SHALL NOT update acc.
REQ-030 SHALL assert err only on the cycle after the offending acceptance; err SHALL be 0 at all other times.

Reset
REQ-031 While rst_n is low, SHALL immediately force state = IDLE, wr_valid = 0, wr_addr = 0, wr_data = 0, acc = 0, err = 0 and busy = 0.
REQ-032 Reset asserted mid-PAIR or mid-WRITE SHALL discard the pending operation; no write SHALL appear after reset is released.
REQ-033 in_ready SHALL be 1 on the first cycle after rst_n rises, provided flush is low.

Verification
REQ-034 ZEXT with in_nib = 4'b0011, rd = 1, and wr_ready held high -> on the next cycle wr_valid = 1, wr_addr = 1, wr_data = 8'h03; one cycle later wr_valid = 0 and acc = 8'h03.
REQ-035 PAIR nib 4'hC, then PAIR nib 4'hA, with wr_ready low for 3 cycles -> wr_data = 8'hAC held stable for 3 cycles with in_ready = 0, then committed.
REQ-036 ZEXT 4'h5 committed, then SHIFT 4'h9 -> wr_data = 8'h59; then SHIFT 4'h1 -> wr_data = 8'h91.
REQ-037 PAIR nib 4'h7, then ZEXT -> err pulses for exactly 1 cycle, state returns to IDLE, and no wr_valid appears; in_op = 11 in IDLE -> err pulses, no write.
REQ-038 flush during WRITE (wr_ready low) -> wr_valid = 0 on the next cycle and acc unchanged; rst_n pulsed low in WAIT_HI -> all outputs reset immediately, and a subsequent PAIR starts a fresh sequence.
